// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if: handshake, instruction fields and memory write port of the encoder/loader
// master drives i_* (start/finish, in_valid, kind, rs/rt/rd, imm, target); slave drives o_* (in_ready, imem_we/addr/wdata, count, full, done, err_illegal)
interface instr_encoder_loader_if #(parameter int ADDR_W = 6);
  logic              i_start;
  logic              i_finish;
  logic              i_in_valid;
  logic [3:0]        i_kind;
  logic [4:0]        i_rs;
  logic [4:0]        i_rt;
  logic [4:0]        i_rd;
  logic [15:0]       i_imm;
  logic [25:0]       i_target;
  logic              o_in_ready;
  logic              o_imem_we;
  logic [ADDR_W-1:0] o_imem_addr;
  logic [31:0]       o_imem_wdata;
  logic [ADDR_W:0]   o_count;
  logic              o_full;
  logic              o_done;
  logic              o_err_illegal;
  modport master (
    output i_start, i_finish, i_in_valid, i_kind, i_rs, i_rt, i_rd, i_imm, i_target,
    input  o_in_ready, o_imem_we, o_imem_addr, o_imem_wdata, o_count, o_full, o_done, o_err_illegal
  );
  modport slave (
    input  i_start, i_finish, i_in_valid, i_kind, i_rs, i_rt, i_rd, i_imm, i_target,
    output o_in_ready, o_imem_we, o_imem_addr, o_imem_wdata, o_count, o_full, o_done, o_err_illegal
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes symbolic MIPS fields into 32-bit words and writes them sequentially to imem
// ports: clk, rst_n (async active-low), bus (slave modport of instr_encoder_loader_if)
module instr_encoder_loader #(
  parameter int ADDR_W = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  instr_encoder_loader_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  state_t            r_state, w_next;
  logic [ADDR_W:0]   r_count, w_count_inc;
  logic              r_we, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, w_word;
  logic [5:0]        w_funct, w_op;
  logic              w_full, w_accept, w_legal, w_write;
  assign w_full      = r_count == DEPTH;
  assign w_count_inc = r_count + 1'b1;
  assign w_legal     = bus.i_kind <= 4'd9;
  assign w_accept    = bus.i_in_valid & bus.o_in_ready;
  assign w_write     = w_accept & w_legal;
  assign w_funct = bus.i_kind == 4'd0 ? 6'b100000 :
                   bus.i_kind == 4'd1 ? 6'b100010 :
                   bus.i_kind == 4'd2 ? 6'b100100 :
                   bus.i_kind == 4'd3 ? 6'b100101 : 6'b101010;
  assign w_op    = bus.i_kind == 4'd5 ? 6'b100011 :
                   bus.i_kind == 4'd6 ? 6'b101011 :
                   bus.i_kind == 4'd7 ? 6'b000100 : 6'b001000;
  assign w_word  = bus.i_kind < 4'd5  ? {6'b000000, bus.i_rs, bus.i_rt, bus.i_rd, 5'b00000, w_funct} :
                   bus.i_kind == 4'd9 ? {6'b000010, bus.i_target} :
                                        {w_op, bus.i_rs, bus.i_rt, bus.i_imm};
  // the accept that fills the last slot leaves LOAD on the same edge
  always_comb begin
    w_next = r_state == LOAD ? ((bus.i_finish || (w_write && w_count_inc == DEPTH)) ? DONE : LOAD) :
             bus.i_start     ? LOAD : r_state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_we <= w_write;
      if (r_state != LOAD && bus.i_start) begin
        r_count <= '0;
        r_err   <= 1'b0;
      end
      if (w_write) begin
        r_addr  <= r_count[ADDR_W-1:0];
        r_wdata <= w_word;
        r_count <= w_count_inc;
      end
      if (w_accept && !w_legal) r_err <= 1'b1;
    end
  end
  assign bus.o_in_ready    = (r_state == LOAD) & !w_full;
  assign bus.o_imem_we     = r_we;
  assign bus.o_imem_addr   = r_addr;
  assign bus.o_imem_wdata  = r_wdata;
  assign bus.o_count       = r_count;
  assign bus.o_full        = w_full;
  assign bus.o_done        = r_state == DONE;
  assign bus.o_err_illegal = r_err;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: table-driven encode checks plus directed multi-cycle sequences, ADDR_W=2
module tb_instr_encoder_loader;
  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t vecs[10];
  instr_encoder_loader_if #(.ADDR_W(2)) bus();
  instr_encoder_loader #(.ADDR_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic apply(input vec_t v);
    bus.i_kind = v.kind; bus.i_rs = v.rs; bus.i_rt = v.rt; bus.i_rd = v.rd;
    bus.i_imm = v.imm; bus.i_target = v.target;
  endtask
  task automatic do_start();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask
  initial begin
    vec_t v;
    int   nw;
    vecs[0] = '{4'd0, 5'd1,  5'd2,  5'd3,  16'hBEEF, 26'h3FFFFFF, 32'h00221820};
    vecs[1] = '{4'd1, 5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,       32'h00221822};
    vecs[2] = '{4'd2, 5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,       32'h00221824};
    vecs[3] = '{4'd3, 5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,       32'h00221825};
    vecs[4] = '{4'd4, 5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,       32'h0022182A};
    vecs[5] = '{4'd5, 5'd9,  5'd8,  5'd7,  16'h0004, 26'h155,     32'h8D280004};
    vecs[6] = '{4'd6, 5'd29, 5'd31, 5'd0,  16'h0000, 26'h0,       32'hAFBF0000};
    vecs[7] = '{4'd7, 5'd1,  5'd2,  5'd0,  16'hFFFF, 26'h0,       32'h1022FFFF};
    vecs[8] = '{4'd8, 5'd5,  5'd6,  5'd31, 16'h1234, 26'h0,       32'h20A61234};
    vecs[9] = '{4'd9, 5'd3,  5'd4,  5'd5,  16'h7777, 26'h0100000, 32'h08100000};
    bus.i_start = 0; bus.i_finish = 0; bus.i_in_valid = 0;
    apply(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.o_in_ready), 0);
    chk("rst_we", 32'(bus.o_imem_we), 0);
    chk("rst_addr", 32'(bus.o_imem_addr), 0);
    chk("rst_wdata", bus.o_imem_wdata, 0);
    chk("rst_count", 32'(bus.o_count), 0);
    chk("rst_full", 32'(bus.o_full), 0);
    chk("rst_done", 32'(bus.o_done), 0);
    chk("rst_err", 32'(bus.o_err_illegal), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 32'(bus.o_in_ready), 0);
    for (int i = 0; i < 10; i++) begin
      if (i % 4 == 0) begin
        do_start();
        chk("start_ready", 32'(bus.o_in_ready), 1);
      end
      apply(vecs[i]);
      bus.i_in_valid = 1'b1;
      tick();
      bus.i_in_valid = 1'b0;
      chk($sformatf("vec%0d_we", i), 32'(bus.o_imem_we), 1);
      chk($sformatf("vec%0d_addr", i), 32'(bus.o_imem_addr), 32'(i % 4));
      chk($sformatf("vec%0d_data", i), bus.o_imem_wdata, vecs[i].exp);
      chk($sformatf("vec%0d_count", i), 32'(bus.o_count), 32'(i % 4 + 1));
      chk($sformatf("vec%0d_done", i), 32'(bus.o_done), 32'(i % 4 == 3));
      tick();
      chk($sformatf("vec%0d_we_drop", i), 32'(bus.o_imem_we), 0);
    end
    bus.i_finish = 1'b1;
    tick();
    bus.i_finish = 1'b0;
    chk("finish_done", 32'(bus.o_done), 1);
    chk("finish_ready", 32'(bus.o_in_ready), 0);
    do_start();
    bus.i_in_valid = 1'b1;
    foreach (vecs[k]) begin
      if (k == 0 || k == 5 || k == 7 || k == 9) begin
        apply(vecs[k]);
        tick();
        chk($sformatf("b2b%0d_we", k), 32'(bus.o_imem_we), 1);
        chk($sformatf("b2b%0d_data", k), bus.o_imem_wdata, vecs[k].exp);
        chk($sformatf("b2b%0d_addr", k), 32'(bus.o_imem_addr), k == 0 ? 0 : k == 5 ? 1 : k == 7 ? 2 : 3);
      end
    end
    bus.i_in_valid = 1'b0;
    chk("b2b_done", 32'(bus.o_done), 1);
    tick();
    chk("b2b_we_end", 32'(bus.o_imem_we), 0);
    do_start();
    apply(vecs[0]);
    bus.i_in_valid = 1'b1;
    nw = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.o_imem_we) begin
        chk("fill_addr", 32'(bus.o_imem_addr), 32'(nw));
        nw++;
      end
    end
    bus.i_in_valid = 1'b0;
    chk("fill_writes", 32'(nw), 4);
    chk("fill_count", 32'(bus.o_count), 4);
    chk("fill_full", 32'(bus.o_full), 1);
    chk("fill_done", 32'(bus.o_done), 1);
    chk("fill_ready", 32'(bus.o_in_ready), 0);
    do_start();
    chk("ill_count0", 32'(bus.o_count), 0);
    chk("ill_full0", 32'(bus.o_full), 0);
    apply(vecs[0]);
    bus.i_in_valid = 1'b1;
    tick();
    chk("ill_w0_addr", 32'(bus.o_imem_addr), 0);
    v = vecs[0];
    v.kind = 4'd12;
    apply(v);
    tick();
    chk("ill_we", 32'(bus.o_imem_we), 0);
    chk("ill_err", 32'(bus.o_err_illegal), 1);
    chk("ill_count", 32'(bus.o_count), 1);
    apply(vecs[1]);
    tick();
    bus.i_in_valid = 1'b0;
    chk("ill_w1_we", 32'(bus.o_imem_we), 1);
    chk("ill_w1_addr", 32'(bus.o_imem_addr), 1);
    chk("ill_w1_data", bus.o_imem_wdata, vecs[1].exp);
    chk("ill_w1_count", 32'(bus.o_count), 2);
    tick();
    chk("ill_err_sticky", 32'(bus.o_err_illegal), 1);
    bus.i_finish = 1'b1;
    tick();
    bus.i_finish = 1'b0;
    chk("ill_err_done", 32'(bus.o_err_illegal), 1);
    do_start();
    chk("ill_err_clr", 32'(bus.o_err_illegal), 0);
    chk("ill_count_clr", 32'(bus.o_count), 0);
    apply(vecs[6]);
    bus.i_in_valid = 1'b1;
    bus.i_finish = 1'b1;
    tick();
    bus.i_in_valid = 1'b0;
    bus.i_finish = 1'b0;
    chk("fin_we", 32'(bus.o_imem_we), 1);
    chk("fin_data", bus.o_imem_wdata, 32'hAFBF0000);
    chk("fin_addr", 32'(bus.o_imem_addr), 0);
    chk("fin_done", 32'(bus.o_done), 1);
    chk("fin_ready", 32'(bus.o_in_ready), 0);
    do_start();
    apply(vecs[0]);
    bus.i_in_valid = 1'b1;
    tick();
    bus.i_in_valid = 1'b0;
    do_start();
    chk("load_start_count", 32'(bus.o_count), 1);
    chk("load_start_done", 32'(bus.o_done), 0);
    chk("load_start_ready", 32'(bus.o_in_ready), 1);
    bus.i_in_valid = 1'b1;
    tick();
    bus.i_in_valid = 1'b0;
    chk("mid_we", 32'(bus.o_imem_we), 1);
    chk("mid_count", 32'(bus.o_count), 2);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_we", 32'(bus.o_imem_we), 0);
    chk("arst_count", 32'(bus.o_count), 0);
    chk("arst_ready", 32'(bus.o_in_ready), 0);
    chk("arst_wdata", bus.o_imem_wdata, 0);
    #2 rst_n = 1'b1;
    bus.i_in_valid = 1'b1;
    tick();
    tick();
    chk("post_rst_ready", 32'(bus.o_in_ready), 0);
    chk("post_rst_we", 32'(bus.o_imem_we), 0);
    chk("post_rst_count", 32'(bus.o_count), 0);
    bus.i_in_valid = 1'b0;
    do_start();
    chk("post_rst_start", 32'(bus.o_in_ready), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
